// File: rtl/encoder_event_queue.sv
// encoder_event_queue
//   Watches the encoder's 16-bit value and queues every change as an event in
//   a small circular FIFO. Firmware reads the queue through a 4-word register
//   window, and a level interrupt is raised while events are pending or lost.
//
// Ports
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   value  : current encoder value
//   addr   : register select (0 = queue, 1 = status, 2 = irq enable, 3 = live value)
//   rd     : read strobe, one cycle per access
//   we     : byte write enables (we[1] -> din[15:8], we[0] -> din[7:0])
//   din    : write data
//   q      : registered read data, updated the cycle after rd
//   irq    : registered level interrupt request
module encoder_event_queue #(
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic [1:0]  addr,
    input  logic        rd,
    input  logic [1:0]  we,
    input  logic [15:0] din,
    output logic [15:0] q,
    output logic        irq
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);
    localparam cnt_t CNT_ONE = cnt_t'(1);
    localparam cnt_t CNT_MAX = cnt_t'(DEPTH);

    logic [15:0] mem_q [DEPTH];
    ptr_t        rd_ptr_q, rd_ptr_d;
    ptr_t        wr_ptr_q, wr_ptr_d;
    cnt_t        count_q, count_d;
    logic [15:0] prev_q;
    logic        overflow_q, overflow_d;
    logic        irq_en_q, irq_en_d;
    logic [15:0] q_q, q_d;
    logic        irq_q, irq_d;

    logic        push, pop, flush, full;
    logic        mem_we;
    ptr_t        mem_waddr;

    // Only din[15] and din[0] are architecturally meaningful.
    logic        unused_din;
    assign unused_din = ^din[14:1];

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        irq_en_d   = irq_en_q;
        q_d        = q_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_ptr_q;

        push  = (value != prev_q);
        flush = (addr == 2'd0) && (we != 2'b00);
        pop   = rd && (addr == 2'd0) && (count_q != '0);
        full  = (count_q == CNT_MAX);

        // Clear first so that an overwrite in the same cycle keeps overflow set.
        if (addr == 2'd1 && we[1] && din[15]) begin
            overflow_d = 1'b0;
        end
        if (addr == 2'd2 && we[0]) begin
            irq_en_d = din[0];
        end

        if (flush) begin
            // Flush discards everything, including an event arriving this cycle.
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push) begin
                mem_we = 1'b1;
                if (!full || pop) begin
                    // When full with a pop, the slot just vacated is wr_ptr.
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                end else begin
                    mem_waddr  = wr_ptr_q - PTR_ONE;
                    overflow_d = 1'b1;
                end
            end
            if (push && !pop && !full) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end

        // Reads observe pre-write state.
        if (rd) begin
            unique case (addr)
                2'd0: q_d = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
                2'd1: begin
                    q_d                = '0;
                    q_d[15]            = overflow_q;
                    q_d[DEPTH_LOG2:0]  = count_q;
                end
                2'd2: q_d = {15'b0, irq_en_q};
                default: q_d = value;
            endcase
        end

        irq_d = irq_en_q && ((count_q != '0) || overflow_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            prev_q     <= '0;
            overflow_q <= 1'b0;
            irq_en_q   <= 1'b0;
            q_q        <= '0;
            irq_q      <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            prev_q     <= value;
            overflow_q <= overflow_d;
            irq_en_q   <= irq_en_d;
            q_q        <= q_d;
            irq_q      <= irq_d;
        end
    end

    // Storage carries no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= value;
        end
    end

    assign q   = q_q;
    assign irq = irq_q;

endmodule
